// File: rtl/adc_fill_reader.sv
// adc_fill_reader
//   Decodes one acquisition fill (header word, num_fill_bursts data words,
//   checksum word) arriving as 128-bit words, and re-emits every accepted
//   word as four 32-bit lanes, low lane first.
//
// Ports
//   clk, reset        : clock; asynchronous active-high reset
//   in_dat/in_valid/in_ready     : 128-bit input word stream
//   out_dat/out_valid/out_ready  : 32-bit lane stream; out_last marks the
//                                  final lane of the checksum word
//   hdr_fill_num, hdr_num_bursts, hdr_fill_type, hdr_channel_tag
//                     : fields of the most recent header
//   hdr_valid         : one-cycle pulse after a header is captured
//   fill_done         : one-cycle pulse after the checksum word is accepted
//   chksum_err        : sticky checksum mismatch flag
//   busy              : fill in progress or lanes still pending
module adc_fill_reader #(
  parameter bit EMIT_HEADER = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] in_dat,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_dat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [23:0]  hdr_fill_num,
  output logic [20:0]  hdr_num_bursts,
  output logic [1:0]   hdr_fill_type,
  output logic [15:0]  hdr_channel_tag,
  output logic         hdr_valid,
  output logic         fill_done,
  output logic         chksum_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, CKSUM} state_t;

  state_t         state;
  state_t         state_nxt;

  logic [127:0]   word_p0;
  logic [1:0]     lane_p0;
  logic           vld_p0;
  logic           last_word_p0;

  logic [20:0]    burst_cnt;
  logic [31:0]    csum;

  logic           hdr_skip;
  logic           lane_xfer;
  logic           lane3_xfer;
  logic           hs;
  logic           emit;

  function automatic logic [31:0] lane_xor(input logic [127:0] w);
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

  // A suppressed header never enters the serializer, so it can be taken
  // regardless of whether lanes are still draining.
  assign hdr_skip   = (state == HDR) && !EMIT_HEADER;
  assign lane_xfer  = vld_p0 && out_ready;
  assign lane3_xfer = lane_xfer && (lane_p0 == 2'd3);
  assign in_ready   = (state != IDLE) && (!vld_p0 || lane3_xfer || hdr_skip);
  assign hs         = in_valid && in_ready;
  assign emit       = hs && !hdr_skip;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = HDR;
      HDR:     if (hs) state_nxt = (in_dat[44:24] == 21'd0) ? CKSUM : DATA;
      DATA:    if (hs && (burst_cnt == 21'd1)) state_nxt = CKSUM;
      CKSUM:   if (hs) state_nxt = HDR;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: fill decode and serializer control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      burst_cnt       <= '0;
      csum            <= '0;
      chksum_err      <= 1'b0;
      hdr_fill_num    <= '0;
      hdr_num_bursts  <= '0;
      hdr_fill_type   <= '0;
      hdr_channel_tag <= '0;
      hdr_valid       <= 1'b0;
      fill_done       <= 1'b0;
      vld_p0          <= 1'b0;
      lane_p0         <= '0;
      last_word_p0    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hdr_valid <= 1'b0;
      fill_done <= 1'b0;
      if (hs) begin
        case (state)
          HDR: begin
            hdr_fill_num    <= in_dat[23:0];
            hdr_num_bursts  <= in_dat[44:24];
            hdr_fill_type   <= in_dat[69:68];
            hdr_channel_tag <= in_dat[85:70];
            hdr_valid       <= 1'b1;
            burst_cnt       <= in_dat[44:24];
            csum            <= '0;
          end
          DATA: begin
            burst_cnt <= burst_cnt - 21'd1;
            csum      <= csum ^ lane_xor(in_dat);
          end
          CKSUM: begin
            fill_done <= 1'b1;
            if (in_dat[31:0] != csum) chksum_err <= 1'b1;
          end
          default: ;
        endcase
      end
      // A new word may load on the same edge lane 3 leaves.
      if (emit) begin
        vld_p0       <= 1'b1;
        lane_p0      <= 2'd0;
        last_word_p0 <= (state == CKSUM);
      end else if (lane_xfer) begin
        if (lane_p0 == 2'd3) vld_p0 <= 1'b0;
        lane_p0 <= lane_p0 + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (emit) word_p0 <= in_dat;
  end

  always_comb begin
    case (lane_p0)
      2'd0:    out_dat = word_p0[31:0];
      2'd1:    out_dat = word_p0[63:32];
      2'd2:    out_dat = word_p0[95:64];
      default: out_dat = word_p0[127:96];
    endcase
  end

  assign out_valid = vld_p0;
  assign out_last  = vld_p0 && last_word_p0 && (lane_p0 == 2'd3);
  assign busy      = (state != IDLE) || vld_p0;

endmodule

// File: tb/tb_adc_fill_reader.sv
module tb_adc_fill_reader;

  logic         clk = 1'b0;
  logic         reset;

  logic [127:0] in_dat;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_dat;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [23:0]  hdr_fill_num;
  logic [20:0]  hdr_num_bursts;
  logic [1:0]   hdr_fill_type;
  logic [15:0]  hdr_channel_tag;
  logic         hdr_valid, fill_done, chksum_err, busy;

  logic [127:0] d1_in_dat;
  logic         d1_in_valid, d1_in_ready;
  logic [31:0]  d1_out_dat;
  logic         d1_out_valid, d1_out_ready, d1_out_last;
  logic [23:0]  d1_hdr_fill_num;
  logic [20:0]  d1_hdr_num_bursts;
  logic [1:0]   d1_hdr_fill_type;
  logic [15:0]  d1_hdr_channel_tag;
  logic         d1_hdr_valid, d1_fill_done, d1_chksum_err, d1_busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 1'b0;

  logic [31:0] rx0[$], rx1[$], exp0[$], exp1[$];
  logic        rx0l[$], rx1l[$], exp0l[$], exp1l[$];
  int          lanepos = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_last;

  adc_fill_reader dut (
    .clk(clk), .reset(reset),
    .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .hdr_fill_num(hdr_fill_num), .hdr_num_bursts(hdr_num_bursts),
    .hdr_fill_type(hdr_fill_type), .hdr_channel_tag(hdr_channel_tag),
    .hdr_valid(hdr_valid), .fill_done(fill_done), .chksum_err(chksum_err), .busy(busy)
  );

  adc_fill_reader #(.EMIT_HEADER(1'b0)) dut_nohdr (
    .clk(clk), .reset(reset),
    .in_dat(d1_in_dat), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .out_dat(d1_out_dat), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_last(d1_out_last),
    .hdr_fill_num(d1_hdr_fill_num), .hdr_num_bursts(d1_hdr_num_bursts),
    .hdr_fill_type(d1_hdr_fill_type), .hdr_channel_tag(d1_hdr_channel_tag),
    .hdr_valid(d1_hdr_valid), .fill_done(d1_fill_done), .chksum_err(d1_chksum_err),
    .busy(d1_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // out_ready changes just after the rising edge so it is settled at the falling edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Lane monitor for the header-emitting instance
  always @(negedge clk) begin
    if (reset) begin
      lanepos    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_vld", out_valid, 1'b1);
        chk("stall_dat", out_dat, prev_dat);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid) begin
        if (!(lanepos == 3 && out_ready)) chk("in_ready_pending", in_ready, 1'b0);
        if (out_ready) begin
          rx0.push_back(out_dat);
          rx0l.push_back(out_last);
          lanepos = (lanepos + 1) % 4;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_dat   = out_dat;
      prev_last  = out_last;
    end
  end

  always @(negedge clk) begin
    if (!reset && d1_out_valid && d1_out_ready) begin
      rx1.push_back(d1_out_dat);
      rx1l.push_back(d1_out_last);
    end
  end

  function automatic logic [31:0] lxor(input logic [127:0] w);
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

  function automatic logic [127:0] mk_hdr(input logic [23:0] fn, input logic [20:0] nb,
                                          input logic [1:0] ft, input logic [15:0] tag);
    return {42'h2AA_AAAA_AAAA, tag, ft, 23'h5A5A5A, nb, fn};
  endfunction

  task automatic push_exp(input int which, input logic [127:0] w, input bit last);
    for (int i = 0; i < 4; i++) begin
      if (which == 0) begin
        exp0.push_back(w[32*i +: 32]);
        exp0l.push_back(last && (i == 3));
      end else begin
        exp1.push_back(w[32*i +: 32]);
        exp1l.push_back(last && (i == 3));
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input int which, input logic [127:0] w);
    bit ok;
    ok = 1'b0;
    if (which == 0) begin in_dat = w; in_valid = 1'b1; end
    else begin d1_in_dat = w; d1_in_valid = 1'b1; end
    for (int t = 0; t < 300 && !ok; t++) begin
      if ((which == 0) ? in_ready : d1_in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) @(negedge clk);
    if (which == 0) in_valid = 1'b0;
    else d1_in_valid = 1'b0;
    chk("send_accepted", ok, 1'b1);
  endtask

  task automatic drain(input int which, input int n);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 800 && !done; t++) begin
      @(negedge clk);
      if (which == 0) done = (rx0.size() >= n) && !out_valid;
      else done = (rx1.size() >= n) && !d1_out_valid;
    end
    if (which == 0) begin
      chk("lane_count", rx0.size(), n);
      for (int i = 0; i < rx0.size() && i < exp0.size(); i++) begin
        chk("lane_dat", rx0[i], exp0[i]);
        chk("lane_last", rx0l[i], exp0l[i]);
      end
      rx0.delete(); rx0l.delete(); exp0.delete(); exp0l.delete();
    end else begin
      chk("nohdr_lane_count", rx1.size(), n);
      for (int i = 0; i < rx1.size() && i < exp1.size(); i++) begin
        chk("nohdr_lane_dat", rx1[i], exp1[i]);
        chk("nohdr_lane_last", rx1l[i], exp1l[i]);
      end
      rx1.delete(); rx1l.delete(); exp1.delete(); exp1l.delete();
    end
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_fill_done", fill_done, 1'b0);
    chk("rst_chksum_err", chksum_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fill_num", hdr_fill_num, 24'h0);
    chk("rst_num_bursts", hdr_num_bursts, 21'h0);
    chk("rst_fill_type", hdr_fill_type, 2'h0);
    chk("rst_channel_tag", hdr_channel_tag, 16'h0);
  endtask

  logic [127:0] h, d0, d1, d2, ck;

  initial begin
    reset = 1'b1;
    in_dat = '0; in_valid = 1'b0;
    d1_in_dat = '0; d1_in_valid = 1'b0; d1_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state, then IDLE for one cycle, then HDR
    check_reset_values();
    chk("rst_nohdr_in_ready", d1_in_ready, 1'b0);
    reset = 1'b0;
    chk("idle_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("hdr_in_ready", in_ready, 1'b1);
    chk("hdr_busy", busy, 1'b1);

    // Two-burst fill, correct checksum
    h  = mk_hdr(24'h000123, 21'd2, 2'd2, 16'hBEEF);
    d0 = 128'h00000001_00000002_00000003_00000004;
    d1 = 128'h10000000_20000000_30000000_40000000;
    ck = {96'hFACE_0000_1111_2222_3333_4444, lxor(d0) ^ lxor(d1)};
    push_exp(0, h, 0); push_exp(0, d0, 0); push_exp(0, d1, 0); push_exp(0, ck, 1);
    send(0, h);
    chk("a_hdr_valid", hdr_valid, 1'b1);
    chk("a_fill_num", hdr_fill_num, 24'h000123);
    chk("a_num_bursts", hdr_num_bursts, 21'd2);
    chk("a_fill_type", hdr_fill_type, 2'd2);
    chk("a_channel_tag", hdr_channel_tag, 16'hBEEF);
    send(0, d0);
    chk("a_hdr_valid_pulse", hdr_valid, 1'b0);
    send(0, d1);
    send(0, ck);
    chk("a_fill_done", fill_done, 1'b1);
    chk("a_chksum_err", chksum_err, 1'b0);
    drain(0, 16);
    chk("a_fill_done_pulse", fill_done, 1'b0);

    // Zero-burst fill: header then checksum of zero
    h  = mk_hdr(24'h00ABCD, 21'd0, 2'd1, 16'h1234);
    ck = {96'h0123_4567_89AB_CDEF_0000_0000, 32'h0};
    push_exp(0, h, 0); push_exp(0, ck, 1);
    send(0, h);
    send(0, ck);
    chk("z_fill_done", fill_done, 1'b1);
    chk("z_chksum_err", chksum_err, 1'b0);
    chk("z_fill_num", hdr_fill_num, 24'h00ABCD);
    drain(0, 8);

    // Wrong checksum: error sets and sticks
    h  = mk_hdr(24'h000123, 21'd2, 2'd2, 16'hBEEF);
    ck = {96'h0, 32'hDEADBEEF};
    push_exp(0, h, 0); push_exp(0, d0, 0); push_exp(0, d1, 0); push_exp(0, ck, 1);
    send(0, h); send(0, d0); send(0, d1);
    chk("b_err_before", chksum_err, 1'b0);
    send(0, ck);
    chk("b_fill_done", fill_done, 1'b1);
    chk("b_chksum_err", chksum_err, 1'b1);
    drain(0, 16);

    ck = {96'h0, lxor(d0) ^ lxor(d1)};
    push_exp(0, h, 0); push_exp(0, d0, 0); push_exp(0, d1, 0); push_exp(0, ck, 1);
    send(0, h); send(0, d0); send(0, d1); send(0, ck);
    chk("b_err_sticky", chksum_err, 1'b1);
    drain(0, 16);

    // Random out_ready back-pressure over a 3-burst fill
    rand_rdy = 1'b1;
    h  = mk_hdr(24'h0F0F0F, 21'd3, 2'd3, 16'h5555);
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    ck = {96'h0, lxor(d0) ^ lxor(d1) ^ lxor(d2)};
    push_exp(0, h, 0); push_exp(0, d0, 0); push_exp(0, d1, 0); push_exp(0, d2, 0);
    push_exp(0, ck, 1);
    send(0, h); send(0, d0); send(0, d1); send(0, d2); send(0, ck);
    drain(0, 20);
    rand_rdy = 1'b0;
    @(negedge clk);

    // Reset after D0 of a 3-burst fill
    h = mk_hdr(24'h000999, 21'd3, 2'd0, 16'h0A0A);
    send(0, h); send(0, d0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    rx0.delete(); rx0l.delete(); exp0.delete(); exp0l.delete();
    rx1.delete(); rx1l.delete(); exp1.delete(); exp1l.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    h  = mk_hdr(24'h000456, 21'd1, 2'd1, 16'hC0DE);
    d0 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    ck = {96'h0, lxor(d0)};
    push_exp(0, h, 0); push_exp(0, d0, 0); push_exp(0, ck, 1);
    send(0, h); send(0, d0); send(0, ck);
    chk("r_fill_done", fill_done, 1'b1);
    chk("r_chksum_err", chksum_err, 1'b0);
    chk("r_fill_num", hdr_fill_num, 24'h000456);
    chk("r_channel_tag", hdr_channel_tag, 16'hC0DE);
    drain(0, 12);

    // Header suppressed: only data and checksum lanes appear
    h  = mk_hdr(24'h000777, 21'd1, 2'd0, 16'h00C1);
    d0 = 128'h11111111_22222222_33333333_44444444;
    ck = {96'h0, lxor(d0)};
    push_exp(1, d0, 0); push_exp(1, ck, 1);
    send(1, h);
    chk("nh_hdr_valid", d1_hdr_valid, 1'b1);
    chk("nh_fill_num", d1_hdr_fill_num, 24'h000777);
    chk("nh_no_lanes", d1_out_valid, 1'b0);
    send(1, d0);
    send(1, ck);
    chk("nh_fill_done", d1_fill_done, 1'b1);
    chk("nh_in_ready_hdr", d1_in_ready, 1'b1);
    chk("nh_chksum_err", d1_chksum_err, 1'b0);
    drain(1, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
